upe_smul16_seq: RTL and testbench

Sequential signed 16×16→32 multiplier controller for the UPE arithmetic path. It sequences the existing resign datapath:
- operands are converted to magnitudes with `upe_resign16u`;
- the magnitudes are multiplied by an iterative shift-add loop;
- the product is re-signed with `upe_resign32u`.

Valid/ready handshakes on both sides let it sit between the UPE operand scheduler and the accumulation stage.

---
 rtl/upe_smul_pkg.sv | 24 ++
 rtl/upe_resign16u.sv | 23 ++
 rtl/upe_resign32u.sv | 18 +
 rtl/upe_smul16_seq.sv | 181 ++++++++++++++++++
 tb/tb_upe_smul16_seq.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/upe_smul_pkg.sv
// ----------------------------------------------------------------------------
// upe_smul_pkg
// Shared definitions for the UPE sequential signed multiplier:
//   - state_t       : controller states
//   - UPE_OPW       : operand width (16)
//   - UPE_PRODW     : product width (32)
//   - UPE_MUL_STEPS : shift-add iterations for a full-width multiplier (16)
// No ports (package).
// ----------------------------------------------------------------------------
package upe_smul_pkg;

    localparam int UPE_OPW       = 16;
    localparam int UPE_PRODW     = 32;
    localparam int UPE_MUL_STEPS = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ABS  = 3'd1,
        ST_MUL  = 3'd2,
        ST_SIGN = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage : upe_smul_pkg

// File: rtl/upe_resign16u.sv
// ----------------------------------------------------------------------------
// upe_resign16u
// Resign datapath cell used by the UPE arithmetic path: converts two 16-bit
// two's-complement operands to their unsigned magnitudes. 0x8000 maps to
// 0x8000, which read as unsigned is the correct magnitude 32768.
// Ports:
//   in1, in2     in  16  two's-complement operands
//   sign1, sign2 in   1  negate the matching operand when set
//   mag1, mag2   out 16  unsigned magnitudes
// ----------------------------------------------------------------------------
module upe_resign16u (
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic        sign1,
    input  logic        sign2,
    output logic [15:0] mag1,
    output logic [15:0] mag2
);

    assign mag1 = sign1 ? (~in1 + 16'd1) : in1;
    assign mag2 = sign2 ? (~in2 + 16'd1) : in2;

endmodule : upe_resign16u

// File: rtl/upe_resign32u.sv
// ----------------------------------------------------------------------------
// upe_resign32u
// Resign datapath cell used by the UPE arithmetic path: applies a sign to a
// 32-bit unsigned magnitude. Negating 0 yields 0, so no -0 is ever produced.
// Ports:
//   din   in  32  unsigned magnitude
//   sign  in   1  negate when set
//   dout  out 32  two's-complement result
// ----------------------------------------------------------------------------
module upe_resign32u (
    input  logic [31:0] din,
    input  logic        sign,
    output logic [31:0] dout
);

    assign dout = sign ? (~din + 32'd1) : din;

endmodule : upe_resign32u

// File: rtl/upe_smul16_seq.sv
// ----------------------------------------------------------------------------
// upe_smul16_seq
// Sequential signed 16x16->32 multiplier controller. Operands are reduced to
// magnitudes (upe_resign16u), multiplied by a one-bit-per-cycle shift-add
// loop, then re-signed (upe_resign32u) into a registered output.
//
// Build option: define UPE_SMUL_EARLY_EXIT_EN to stop the shift-add loop as
// soon as the remaining multiplier magnitude is zero. Results are identical;
// latency becomes 3 + bit-length(|In2|). Undefined: fixed 19-cycle latency.
//
// Ports:
//   clk        in   1   rising-edge clock
//   reset_n    in   1   asynchronous active-low reset
//   In1        in   16  signed multiplicand
//   In2        in   16  signed multiplier
//   in_valid   in   1   operands valid
//   in_ready   out  1   ready for operands (IDLE only)
//   Out        out  32  signed product, registered
//   out_valid  out  1   Out valid, held until out_ready
//   out_ready  in   1   consumer accepts Out (DONE only)
//   busy       out  1   any state other than IDLE
// ----------------------------------------------------------------------------
module upe_smul16_seq
    import upe_smul_pkg::*;
#(
    parameter int WIDTH = UPE_OPW
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     In1,
    input  logic [WIDTH-1:0]     In2,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   Out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam logic [3:0] LAST_STEP = 4'(UPE_MUL_STEPS - 1);

    state_t               state_q;
    state_t               state_d;

    logic [UPE_OPW-1:0]   a_r;
    logic [UPE_OPW-1:0]   b_r;
    logic [UPE_OPW-1:0]   ma;
    logic [UPE_OPW-1:0]   mb;
    logic                 psign;
    logic [UPE_PRODW-1:0] acc;
    logic [3:0]           cnt;

    logic [UPE_OPW-1:0]   mag_a;
    logic [UPE_OPW-1:0]   mag_b;
    logic [UPE_PRODW-1:0] prod_signed;

    // Early-exit decisions. The zero test is made one cycle ahead (on the
    // magnitude entering MUL, or on the multiplier after this step's shift)
    // so no MUL cycle is ever spent on an exhausted multiplier.
    logic                 skip_mul;
    logic                 mb_empty_next;

`ifdef UPE_SMUL_EARLY_EXIT_EN
    assign skip_mul      = (mag_b == '0);
    assign mb_empty_next = ((mb >> 1) == '0);
`else
    assign skip_mul      = 1'b0;
    assign mb_empty_next = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Resign datapath instances
    // ------------------------------------------------------------------
    upe_resign16u u_abs (
        .in1   (a_r),
        .in2   (b_r),
        .sign1 (a_r[UPE_OPW-1]),
        .sign2 (b_r[UPE_OPW-1]),
        .mag1  (mag_a),
        .mag2  (mag_b)
    );

    upe_resign32u u_sign (
        .din   (acc),
        .sign  (psign),
        .dout  (prod_signed)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment before the case keeps every path
    // assigned, so this stays pure combinational logic with no latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (in_valid)                            state_d = ST_ABS;
            ST_ABS:  state_d = skip_mul ? ST_SIGN : ST_MUL;
            ST_MUL:  if (cnt == LAST_STEP || mb_empty_next)   state_d = ST_SIGN;
            ST_SIGN: state_d = ST_DONE;
            ST_DONE: if (out_ready)                           state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = (state_q == ST_IDLE);
        busy     = (state_q != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // NOTE: every datapath register is reset, not only control; a reset in
    // mid-MUL must leave no partial product or sign behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_r       <= '0;
            b_r       <= '0;
            ma        <= '0;
            mb        <= '0;
            psign     <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            Out       <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r <= In1;
                        b_r <= In2;
                    end
                end
                ST_ABS: begin
                    ma    <= mag_a;
                    mb    <= mag_b;
                    psign <= a_r[UPE_OPW-1] ^ b_r[UPE_OPW-1];
                    acc   <= '0;
                    cnt   <= '0;
                end
                ST_MUL: begin
                    // Magnitudes are at most 2^15, so the sum never exceeds
                    // 2^30 and cannot overflow 32 bits.
                    if (mb[0]) begin
                        acc <= acc + (UPE_PRODW'(ma) << cnt);
                    end
                    mb  <= mb >> 1;
                    cnt <= cnt + 4'd1;
                end
                ST_SIGN: begin
                    Out       <= prod_signed;
                    out_valid <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : upe_smul16_seq

// File: tb/tb_upe_smul16_seq.sv
// ----------------------------------------------------------------------------
// tb_upe_smul16_seq
// Self-checking bench for upe_smul16_seq: a table of directed products with
// latency/busy/ready checks, back-pressure and mid-operation reset sequences,
// then 1000 random operand pairs with random out_ready gaps scored against an
// integer-multiply reference. Honours UPE_SMUL_EARLY_EXIT_EN for latency.
// ----------------------------------------------------------------------------
module tb_upe_smul16_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] In1;
    logic [15:0] In2;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    always #5 clk = ~clk;

    upe_smul16_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .In1       (In1),
        .In2       (In2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Out       (Out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference product: plain signed integer multiply.
    function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return 32'(p);
    endfunction

    // Cycles from accept edge to the edge where out_valid first rises.
    function automatic int exp_latency(input logic [15:0] b);
`ifdef UPE_SMUL_EARLY_EXIT_EN
        int m;
        int n;
        m = int'($signed(b));
        if (m < 0) m = -m;
        n = 0;
        while (m != 0) begin
            n++;
            m = m / 2;
        end
        return 3 + n;
`else
        return (b === 16'hxxxx) ? 0 : 19;
`endif
    endfunction

    function automatic logic [15:0] pick_operand();
        logic [15:0] corners [5];
        corners = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0001, 16'hFFFF};
        if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 4)];
        return 16'($urandom);
    endfunction

    // One full operation from IDLE: accept, wait for result, optional
    // back-pressure (with ignored in_valid pulses), handshake.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                         output logic [31:0] res, output int lat,
                         output logic ok, output logic idle_ok);
        int t;
        ok        = 1'b1;
        out_ready = (hold == 0);
        In1       = a;
        In2       = b;
        in_valid  = 1'b1;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        In1      = 16'($urandom);
        In2      = 16'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
        res = Out;
        for (int i = 0; i < hold; i++) begin
            in_valid = (i % 2 == 0);
            In1      = 16'($urandom);
            In2      = 16'($urandom);
            @(negedge clk);
            if (Out !== res || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        idle_ok = (in_ready === 1'b1) && (out_valid === 1'b0) && (busy === 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Scoreboard monitor (random phase) and ready/valid exclusivity check
    // ------------------------------------------------------------------
    logic        mon_en    = 1'b0;
    logic        rand_phase = 1'b0;
    logic [31:0] exp_q[$];
    int          n_in  = 0;
    int          n_out = 0;

    always begin
        @(negedge clk);
        #1;
        if (reset_n === 1'b1) check("in_ready_with_out_valid", 32'(in_ready & out_valid), 32'd0);
        if (mon_en) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_prod(In1, In2));
                n_in++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() > 0) check("rand_product", Out, exp_q.pop_front());
            end
        end
    end

    always begin
        @(negedge clk);
        if (rand_phase) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] prod;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [31:0] res;
        int          lat;
        logic        ok;
        logic        idle_ok;
        int          t;
        int          spur;

        vecs[0] = '{"3x-5",          16'h0003, 16'hFFFB, 32'hFFFFFFF1};
        vecs[1] = '{"min_x_min",     16'h8000, 16'h8000, 32'h40000000};
        vecs[2] = '{"max_x_max",     16'h7FFF, 16'h7FFF, 32'h3FFF0001};
        vecs[3] = '{"min_x_1",       16'h8000, 16'h0001, 32'hFFFF8000};
        vecs[4] = '{"0x-7",          16'h0000, 16'hFFF9, 32'h00000000};
        vecs[5] = '{"-7x0",          16'hFFF9, 16'h0000, 32'h00000000};
        vecs[6] = '{"max_x_min",     16'h7FFF, 16'h8000, 32'hC0008000};
        vecs[7] = '{"-1_x_max",      16'hFFFF, 16'h7FFF, 32'hFFFF8001};
        vecs[8] = '{"-1_x_-1",       16'hFFFF, 16'hFFFF, 32'h00000001};
        vecs[9] = '{"1x1",           16'h0001, 16'h0001, 32'h00000001};

        reset_n   = 1'b0;
        In1       = '0;
        In2       = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_Out",       Out,               32'd0);
        check("reset_out_valid", 32'(out_valid),    32'd0);
        check("reset_busy",      32'(busy),         32'd0);
        check("reset_in_ready",  32'(in_ready),     32'd1);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, 0, res, lat, ok, idle_ok);
            check({vecs[i].name, "_product"}, res, vecs[i].prod);
            check({vecs[i].name, "_latency"}, 32'(lat), 32'(exp_latency(vecs[i].b)));
            check({vecs[i].name, "_busy_window"}, 32'(ok), 32'd1);
            check({vecs[i].name, "_idle_after"}, 32'(idle_ok), 32'd1);
        end

        // Back-pressure: 10 cycles of out_ready low with in_valid pulses
        do_op(16'h0064, 16'hFF9C, 10, res, lat, ok, idle_ok);
        check("bp_product",     res,          32'hFFFFD8F0);
        check("bp_latency",     32'(lat),     32'(exp_latency(16'hFF9C)));
        check("bp_hold_stable", 32'(ok),      32'd1);
        check("bp_idle_after",  32'(idle_ok), 32'd1);
        check("bp_not_started", 32'(busy),    32'd0);

        // Reset during MUL step 8
        In1      = 16'h0005;
        In2      = 16'h0007;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midreset_busy",      32'(busy),      32'd0);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_Out",       Out,            32'd0);
        check("midreset_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        spur = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) spur++;
        end
        check("post_reset_quiet", 32'(spur), 32'd0);
        do_op(16'hFFFE, 16'h0006, 0, res, lat, ok, idle_ok);
        check("post_reset_product", res,      32'hFFFFFFF4);
        check("post_reset_latency", 32'(lat), 32'(exp_latency(16'h0006)));

        // Random phase
        mon_en     = 1'b1;
        rand_phase = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            In1      = pick_operand();
            In2      = pick_operand();
            in_valid = 1'b1;
            #1;
            t = 0;
            while (in_ready !== 1'b1 && t < 500) begin
                @(negedge clk);
                #1;
                t++;
            end
            if (in_ready !== 1'b1) begin
                check("rand_accept_timeout", 32'(in_ready), 32'd1);
                break;
            end
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
        t = 0;
        while ((exp_q.size() != 0 || out_valid === 1'b1) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        rand_phase = 1'b0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        check("rand_accepted", 32'(n_in),         32'd1000);
        check("rand_results",  32'(n_out),        32'd1000);
        check("rand_drained",  32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_upe_smul16_seq
